// File: rtl/score_digit_controller.sv
// rtl/score_digit_controller.sv - BCD score/hiscore owner with ripple adder FSM and snapshot digit lookup
module score_digit_controller #(
    parameter int NUM_DIGITS = 4,
    parameter bit LZ_BLANK   = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    score_inc,
    input  logic [3:0]              score_amt,
    output logic                    inc_ready,
    input  logic                    score_clr,
    input  logic                    frame_start,
    input  logic                    req_valid,
    input  logic                    req_sel,
    input  logic [2:0]              req_digit,
    output logic                    req_ready,
    output logic                    rsp_valid,
    output logic [6:0]              rsp_seg,
    output logic [4*NUM_DIGITS-1:0] score_bcd,
    output logic [4*NUM_DIGITS-1:0] hiscore_bcd,
    output logic                    overflow
);
    localparam int             W         = 4 * NUM_DIGITS;
    localparam logic [2:0]     LAST_IDX  = 3'(NUM_DIGITS - 1);
    localparam logic [W-1:0]   ALL_NINES = {NUM_DIGITS{4'h9}};

    typedef enum logic [1:0] {IDLE, ADD, COMMIT} state_t;
    state_t state, state_next;

    logic [W-1:0] acc, acc_add, commit_val;
    logic [W-1:0] snap_score, snap_hi, lk_snap;
    logic [3:0]   carry, carry_add, cur_digit, amt_sat, start_amt;
    logic [3:0]   slot_amt, lk_nib;
    logic [4:0]   digit_sum;
    logic [2:0]   idx;
    logic         slot_valid, hi_chk, start_add;
    logic         lk_upper_zero, lk_range;
    logic [6:0]   lk_seg;

    function automatic logic [6:0] rom_seg(input logic [3:0] d);
        case (d)
            4'd0:    rom_seg = 7'b0111111;
            4'd1:    rom_seg = 7'b0000110;
            4'd2:    rom_seg = 7'b1011011;
            4'd3:    rom_seg = 7'b1001111;
            4'd4:    rom_seg = 7'b1100110;
            4'd5:    rom_seg = 7'b1101101;
            4'd6:    rom_seg = 7'b1111101;
            4'd7:    rom_seg = 7'b0000111;
            4'd8:    rom_seg = 7'b1111111;
            4'd9:    rom_seg = 7'b1101111;
            default: rom_seg = 7'b0000000;
        endcase
    endfunction

    // One BCD digit of the accumulator is updated per ADD cycle.
    always_comb begin
        amt_sat   = (score_amt > 4'd9) ? 4'd9 : score_amt;
        cur_digit = 4'd0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx == 3'(i)) cur_digit = acc[i*4 +: 4];
        end
        digit_sum = {1'b0, cur_digit} + {1'b0, carry};
        acc_add   = acc;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx == 3'(i)) begin
                acc_add[i*4 +: 4] = (digit_sum >= 5'd10) ? 4'(digit_sum - 5'd10) : digit_sum[3:0];
            end
        end
        carry_add  = (digit_sum >= 5'd10) ? 4'd1 : 4'd0;
        commit_val = (carry != 4'd0) ? ALL_NINES : acc;
    end

    always_comb begin
        state_next = state;
        start_add  = 1'b0;
        start_amt  = amt_sat;
        case (state)
            IDLE: begin
                if (score_inc) begin
                    start_add  = 1'b1;
                    state_next = ADD;
                end
            end
            ADD: begin
                if (idx == LAST_IDX) state_next = COMMIT;
            end
            COMMIT: begin
                if (slot_valid) begin
                    start_add  = 1'b1;
                    start_amt  = slot_amt;
                    state_next = ADD;
                end else if (score_inc) begin
                    start_add  = 1'b1;
                    state_next = ADD;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
        if (score_clr) begin
            state_next = IDLE;
            start_add  = 1'b0;
        end
    end

    assign inc_ready = (state == IDLE) | ~slot_valid;
    assign req_ready = 1'b1;

    // Lookups only ever see the frame snapshots so a frame never shows a half-added score.
    always_comb begin
        lk_snap       = req_sel ? snap_hi : snap_score;
        lk_nib        = 4'd0;
        lk_upper_zero = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (3'(i) == req_digit) lk_nib = lk_snap[i*4 +: 4];
            if ((4'(i) >= {1'b0, req_digit}) && (lk_snap[i*4 +: 4] != 4'd0)) lk_upper_zero = 1'b0;
        end
        lk_range = {1'b0, req_digit} < 4'(NUM_DIGITS);
        if (!lk_range || (LZ_BLANK && (req_digit != 3'd0) && lk_upper_zero)) begin
            lk_seg = 7'b0000000;
        end else begin
            lk_seg = rom_seg(lk_nib);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            acc         <= '0;
            carry       <= 4'd0;
            idx         <= 3'd0;
            slot_valid  <= 1'b0;
            slot_amt    <= 4'd0;
            score_bcd   <= '0;
            hiscore_bcd <= '0;
            overflow    <= 1'b0;
            hi_chk      <= 1'b0;
            snap_score  <= '0;
            snap_hi     <= '0;
            rsp_valid   <= 1'b0;
            rsp_seg     <= 7'b0;
        end else begin
            state <= state_next;
            if (score_clr) begin
                score_bcd  <= '0;
                overflow   <= 1'b0;
                slot_valid <= 1'b0;
                hi_chk     <= 1'b0;
            end else begin
                hi_chk <= (state == COMMIT);
                if (state == ADD) begin
                    acc   <= acc_add;
                    carry <= carry_add;
                    idx   <= idx + 3'd1;
                end
                if (state == COMMIT) begin
                    score_bcd <= commit_val;
                    if (carry != 4'd0) overflow <= 1'b1;
                end
                // A chained add starts from the value being committed this edge.
                if (start_add) begin
                    acc   <= (state == COMMIT) ? commit_val : score_bcd;
                    carry <= start_amt;
                    idx   <= 3'd0;
                end
                if ((state == ADD) && score_inc && !slot_valid) begin
                    slot_valid <= 1'b1;
                    slot_amt   <= amt_sat;
                end else if ((state == COMMIT) && slot_valid) begin
                    slot_valid <= 1'b0;
                end
            end
            if (hi_chk && (score_bcd > hiscore_bcd)) hiscore_bcd <= score_bcd;
            if (frame_start) begin
                snap_score <= score_bcd;
                snap_hi    <= hiscore_bcd;
            end
            rsp_valid <= req_valid;
            rsp_seg   <= req_valid ? lk_seg : 7'b0;
        end
    end
endmodule

// File: tb/tb_score_digit_controller.sv
// tb/tb_score_digit_controller.sv - scoreboard bench for score_digit_controller
module tb_score_digit_controller;
    logic        clk = 1'b0;
    logic        rst_n, score_inc, score_clr, frame_start, req_valid, req_sel;
    logic [3:0]  score_amt;
    logic [2:0]  req_digit;
    logic        inc_ready, req_ready, rsp_valid, overflow;
    logic [6:0]  rsp_seg;
    logic [15:0] score_bcd, hiscore_bcd;

    always #5 clk = ~clk;

    score_digit_controller #(.NUM_DIGITS(4), .LZ_BLANK(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .score_inc(score_inc), .score_amt(score_amt),
        .inc_ready(inc_ready), .score_clr(score_clr), .frame_start(frame_start),
        .req_valid(req_valid), .req_sel(req_sel), .req_digit(req_digit),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_seg(rsp_seg),
        .score_bcd(score_bcd), .hiscore_bcd(hiscore_bcd), .overflow(overflow)
    );

    typedef struct {int due; logic [15:0] val; logic ovf;} sc_t;
    typedef struct {int due; logic [6:0] seg;} rs_t;
    sc_t sq[$];
    sc_t hq[$];
    rs_t rq[$];

    int cyc = 0;
    int checks = 0;
    int failures = 0;
    bit mon_en = 1'b0;
    int m_score, m_hi, last_due, snap_s, snap_h, g_t;
    bit m_ovf;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] bcd(input int v);
        logic [15:0] r;
        int t;
        t = v;
        for (int i = 0; i < 4; i++) begin
            r[i*4 +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    function automatic logic [6:0] seg7(input int d);
        case (d)
            0: return 7'b0111111;
            1: return 7'b0000110;
            2: return 7'b1011011;
            3: return 7'b1001111;
            4: return 7'b1100110;
            5: return 7'b1101101;
            6: return 7'b1111101;
            7: return 7'b0000111;
            8: return 7'b1111111;
            9: return 7'b1101111;
            default: return 7'b0;
        endcase
    endfunction

    function automatic logic [6:0] exp_seg(input int v, input int d);
        int pw;
        if (d >= 4) return 7'b0;
        pw = 1;
        for (int i = 0; i < d; i++) pw = pw * 10;
        if (d > 0 && (v / pw) == 0) return 7'b0;
        return seg7((v / pw) % 10);
    endfunction

    always @(negedge clk) begin
        if (mon_en) begin
            while (sq.size() > 0 && sq[0].due <= cyc) begin
                checks++;
                if (sq[0].due != cyc || score_bcd !== sq[0].val || overflow !== sq[0].ovf) begin
                    failures++;
                    $display("FAIL score_sb cyc=%0d: score=%h ovf=%b, required score=%h ovf=%b at cyc %0d",
                             cyc, score_bcd, overflow, sq[0].val, sq[0].ovf, sq[0].due);
                end
                void'(sq.pop_front());
            end
            while (hq.size() > 0 && hq[0].due <= cyc) begin
                checks++;
                if (hq[0].due != cyc || hiscore_bcd !== hq[0].val) begin
                    failures++;
                    $display("FAIL hiscore_sb cyc=%0d: hiscore=%h, required %h at cyc %0d",
                             cyc, hiscore_bcd, hq[0].val, hq[0].due);
                end
                void'(hq.pop_front());
            end
            checks++;
            if (rq.size() > 0 && rq[0].due == cyc) begin
                if (rsp_valid !== 1'b1 || rsp_seg !== rq[0].seg) begin
                    failures++;
                    $display("FAIL lookup_sb cyc=%0d: valid=%b seg=%b, required valid=1 seg=%b",
                             cyc, rsp_valid, rsp_seg, rq[0].seg);
                end
                void'(rq.pop_front());
            end else if (rsp_valid !== 1'b0) begin
                failures++;
                $display("FAIL rsp_idle cyc=%0d: rsp_valid=%b, required 0", cyc, rsp_valid);
            end
        end
    end

    task automatic model_accept(input int amt);
        int t, due, a;
        t = cyc + 1;
        g_t = t;
        due = ((t > last_due) ? t : last_due) + 5;
        last_due = due;
        a = (amt > 9) ? 9 : amt;
        m_score = m_score + a;
        if (m_score > 9999) begin
            m_score = 9999;
            m_ovf = 1'b1;
        end
        if (m_score > m_hi) m_hi = m_score;
        sq.push_back('{due, bcd(m_score), m_ovf});
        hq.push_back('{due + 1, bcd(m_hi), 1'b0});
    endtask

    task automatic do_add(input int amt);
        int n;
        n = 0;
        while (inc_ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            failures++;
            $display("FAIL inc_ready_timeout: inc_ready=%b, required 1 within 200 cycles", inc_ready);
        end
        score_inc = 1'b1;
        score_amt = 4'(amt);
        model_accept(amt);
        @(negedge clk);
        score_inc = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sq.size() > 0 || hq.size() > 0 || rq.size() > 0) && n < 300) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 300) begin
            failures++;
            $display("FAIL drain_timeout: pending=%0d, required 0", sq.size() + hq.size() + rq.size());
        end
    endtask

    task automatic frame(input int s, input int h);
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        snap_s = s;
        snap_h = h;
    endtask

    task automatic lookup(input logic sel, input int d);
        req_valid = 1'b1;
        req_sel   = sel;
        req_digit = 3'(d);
        rq.push_back('{cyc + 1, exp_seg(sel ? snap_h : snap_s, d)});
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; score_inc = 0; score_amt = 0; score_clr = 0;
        frame_start = 0; req_valid = 0; req_sel = 0; req_digit = 0;
        m_score = 0; m_hi = 0; m_ovf = 0; last_due = 0; snap_s = 0; snap_h = 0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        mon_en = 1'b1;
        checks++;
        if (score_bcd !== 16'h0 || hiscore_bcd !== 16'h0 || overflow !== 1'b0 ||
            inc_ready !== 1'b1 || req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_state: score=%h hi=%h ovf=%b ready=%b rreq=%b rsp=%b, required 0 0 0 1 1 0",
                     score_bcd, hiscore_bcd, overflow, inc_ready, req_ready, rsp_valid);
        end
        frame(0, 0);
        for (int d = 0; d < 4; d++) lookup(1'b0, d);
        lookup(1'b0, 5);
        lookup(1'b1, 0);
        drain();
    endtask

    task automatic test_carry_ripple();
        for (int i = 0; i < 111; i++) do_add(9);
        drain();
        do_add(1);
        repeat (4) @(negedge clk);
        checks++;
        if (score_bcd !== 16'h0999) begin
            failures++;
            $display("FAIL ripple_early: score=%h at T+4, required 0999", score_bcd);
        end
        @(negedge clk);
        checks++;
        if (score_bcd !== 16'h1000 || hiscore_bcd !== 16'h0999) begin
            failures++;
            $display("FAIL ripple_commit: score=%h hi=%h, required 1000 0999", score_bcd, hiscore_bcd);
        end
        @(negedge clk);
        checks++;
        if (hiscore_bcd !== 16'h1000) begin
            failures++;
            $display("FAIL ripple_hiscore: hi=%h, required 1000", hiscore_bcd);
        end
        drain();
    endtask

    task automatic test_overflow_clear();
        for (int i = 0; i < 999; i++) do_add(9);
        do_add(4);
        drain();
        checks++;
        if (score_bcd !== 16'h9995 || overflow !== 1'b0) begin
            failures++;
            $display("FAIL pre_overflow: score=%h ovf=%b, required 9995 0", score_bcd, overflow);
        end
        do_add(7);
        do_add(12);
        drain();
        checks++;
        if (score_bcd !== 16'h9999 || overflow !== 1'b1) begin
            failures++;
            $display("FAIL overflow: score=%h ovf=%b, required 9999 1", score_bcd, overflow);
        end
        score_clr = 1'b1;
        @(negedge clk);
        score_clr = 1'b0;
        m_score = 0; m_ovf = 0;
        checks++;
        if (score_bcd !== 16'h0 || overflow !== 1'b0 || hiscore_bcd !== 16'h9999) begin
            failures++;
            $display("FAIL clear: score=%h ovf=%b hi=%h, required 0000 0 9999", score_bcd, overflow, hiscore_bcd);
        end
    endtask

    task automatic test_back_to_back();
        m_hi = 9999;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (inc_ready !== (k < 2)) begin
                failures++;
                $display("FAIL b2b_ready k=%0d: inc_ready=%b, required %b", k, inc_ready, (k < 2));
            end
            score_inc = 1'b1;
            score_amt = 4'd5;
            if (k < 2) model_accept(5);
            @(negedge clk);
        end
        score_inc = 1'b0;
        drain();
        checks++;
        if (score_bcd !== 16'h0010) begin
            failures++;
            $display("FAIL b2b_final: score=%h, required 0010", score_bcd);
        end
    endtask

    task automatic test_abort();
        score_inc = 1'b1; score_amt = 4'd3;
        @(negedge clk);
        score_inc = 1'b0;
        @(negedge clk);
        score_clr = 1'b1; score_inc = 1'b1; score_amt = 4'd2;
        @(negedge clk);
        score_clr = 1'b0; score_inc = 1'b0;
        checks++;
        if (score_bcd !== 16'h0 || inc_ready !== 1'b1 || overflow !== 1'b0) begin
            failures++;
            $display("FAIL clr_mid_add: score=%h ready=%b ovf=%b, required 0000 1 0", score_bcd, inc_ready, overflow);
        end
        repeat (8) @(negedge clk);
        checks++;
        if (score_bcd !== 16'h0 || hiscore_bcd !== 16'h9999) begin
            failures++;
            $display("FAIL clr_discard: score=%h hi=%h, required 0000 9999", score_bcd, hiscore_bcd);
        end
        score_inc = 1'b1; score_amt = 4'd4;
        @(negedge clk);
        score_inc = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        m_score = 0; m_hi = 0; m_ovf = 0; last_due = 0; snap_s = 0; snap_h = 0;
        checks++;
        if (score_bcd !== 16'h0 || hiscore_bcd !== 16'h0 || inc_ready !== 1'b1) begin
            failures++;
            $display("FAIL rst_mid_add: score=%h hi=%h ready=%b, required 0000 0000 1", score_bcd, hiscore_bcd, inc_ready);
        end
        repeat (8) @(negedge clk);
        checks++;
        if (score_bcd !== 16'h0) begin
            failures++;
            $display("FAIL rst_discard: score=%h, required 0000", score_bcd);
        end
    endtask

    task automatic test_snapshot_commit();
        int pre;
        do_add(9); do_add(9); do_add(9); do_add(9); do_add(5);
        drain();
        pre = m_score;
        do_add(1);
        while (cyc < g_t + 4) @(negedge clk);
        frame(pre, m_hi - 1);
        lookup(1'b0, 0);
        lookup(1'b0, 1);
        lookup(1'b0, 2);
        lookup(1'b0, 3);
        lookup(1'b1, 0);
        lookup(1'b1, 7);
        drain();
        frame(m_score, m_hi);
        lookup(1'b0, 0);
        lookup(1'b1, 1);
        drain();
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_carry_ripple();
        test_overflow_clear();
        test_back_to_back();
        test_abort();
        test_snapshot_commit();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
